// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl: valid/ready FIFO front end for simple_dual_port_ram (port A write, port B read).
// Latency: push in cycle N -> ram_renb N+1 -> ram_dvalb N+2 -> m_valid N+3; one push + one pop per cycle sustained.
// Backpressure: s_ready = !full from registered count; reads stop while the 2-entry output buffer would overflow.
//
// Ports:
//   clk, rst (async, active low)
//   s_valid/s_data/s_ready      push stream
//   m_valid/m_data/m_ready      pop stream (registered outputs)
//   ram_addra/ram_wena/ram_dina write port A (combinational from s_valid/s_data)
//   ram_addrb/ram_renb          read port B issue (ram_renb combinational from m_ready)
//   ram_doutb/ram_dvalb         read port B return, one cycle after ram_renb
//   count/full/empty            occupancy (RAM + in flight + output buffer)
//   lat_err                     sticky read-latency error
// Optional feature: define SDPRAM_FIFO_LATCHK_EN to build the read-latency checker
// behind lat_err; otherwise lat_err is tied low.

module sdpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [STRB_WIDTH-1:0] ram_wena,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_renb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  input  logic                  ram_dvalb,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  lat_err
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [ADDR_WIDTH:0]   count_q;

  // Output buffer: two registered entries, head selected by ob_rd.
  logic [DATA_WIDTH-1:0] ob_mem [0:1];
  logic                  ob_wr;
  logic                  ob_rd;
  logic [1:0]            ob_cnt;

  logic                  inflight;   // ram_renb was high last cycle
  logic                  post_rst;   // high only in the first cycle after reset release

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  capture;
  logic [2:0]            occ_after;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign s_ready = !full;
  assign push    = s_valid && s_ready;

  assign m_valid = (ob_cnt != 2'd0);
  assign m_data  = ob_mem[ob_rd];
  assign pop     = m_valid && m_ready;

  // Port A: drive data/strobes only on an accepted push so idle outputs stay at zero.
  assign ram_addra = wr_ptr;
  assign ram_wena  = push ? {STRB_WIDTH{1'b1}} : {STRB_WIDTH{1'b0}};
  assign ram_dina  = push ? s_data : {DATA_WIDTH{1'b0}};

  // Issue a read only if the word will fit in the output buffer when it returns,
  // counting a word already in flight and credit freed by a pop this cycle.
  assign occ_after = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (ram_cnt != '0) && (occ_after < 3'd2);
  assign ram_renb  = issue;
  assign ram_addrb = rd_ptr;

  // Data returning from a read launched before reset is dropped.
  assign capture = ram_dvalb && !post_rst && (ob_cnt != 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      count_q  <= '0;
      inflight <= 1'b0;
      post_rst <= 1'b1;
    end else begin
      post_rst <= 1'b0;
      inflight <= issue;
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
        2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
        default: ram_cnt <= ram_cnt;
      endcase
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_mem[0] <= '0;
      ob_mem[1] <= '0;
      ob_wr     <= 1'b0;
      ob_rd     <= 1'b0;
      ob_cnt    <= 2'd0;
    end else begin
      if (capture) begin
        ob_mem[ob_wr] <= ram_doutb;
        ob_wr         <= ~ob_wr;
      end
      if (pop) ob_rd <= ~ob_rd;
      case ({capture, pop})
        2'b10:   ob_cnt <= ob_cnt + 2'd1;
        2'b01:   ob_cnt <= ob_cnt - 2'd1;
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

`ifdef SDPRAM_FIFO_LATCHK_EN
  logic lat_err_q;

  // Every read must return exactly one cycle after issue, in both directions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_err_q <= 1'b0;
    end else if (!post_rst && (ram_dvalb != inflight)) begin
      lat_err_q <= 1'b1;
    end
  end

  assign lat_err = lat_err_q;
`else
  assign lat_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// tb_sdpram_fifo_ctrl: directed and scoreboarded stimulus for sdpram_fifo_ctrl with a behavioural RAM.
// Latency: not applicable (bench).
// Backpressure: m_ready driven by the stimulus tasks.

module tb_sdpram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [AW-1:0] ram_addra;
  logic [SW-1:0] ram_wena;
  logic [DW-1:0] ram_dina;
  logic [AW-1:0] ram_addrb;
  logic          ram_renb;
  logic [DW-1:0] ram_doutb;
  logic          ram_dvalb;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          lat_err;

  logic          force_dval;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic          dval_q;

  int n_chk;
  int n_fail;

  sdpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .ram_addra(ram_addra), .ram_wena(ram_wena), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_renb(ram_renb),
    .ram_doutb(ram_doutb), .ram_dvalb(ram_dvalb),
    .count(count), .full(full), .empty(empty), .lat_err(lat_err)
  );

  // Behavioural simple_dual_port_ram: byte-strobed write, 1-cycle registered read.
  always @(posedge clk) begin
    for (int b = 0; b < SW; b++)
      if (ram_wena[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    if (ram_renb) rd_q <= mem[ram_addrb];
    dval_q <= ram_renb;
  end
  assign ram_doutb = rd_q;
  assign ram_dvalb = dval_q | force_dval;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {s_ready,m_valid,m_data,ram_addra,ram_wena,ram_dina,ram_addrb,ram_renb,count,full,empty,lat_err}
  localparam int RV_W = 1 + 1 + DW + AW + SW + DW + AW + 1 + (AW + 1) + 3;
  localparam logic [RV_W-1:0] RST_VEC = {1'b1, 1'b0, 32'h0, 8'h0, 4'h0, 32'h0, 8'h0, 1'b0, 9'h0, 1'b0, 1'b1, 1'b0};

  task automatic test_reset;
    logic [RV_W-1:0] obs;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {s_ready, m_valid, m_data, ram_addra, ram_wena, ram_dina, ram_addrb, ram_renb, count, full, empty, lat_err};
    n_chk++;
    if (obs !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", obs, RST_VEC);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({empty, s_ready, count} !== {1'b1, 1'b1, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_release: empty=%b s_ready=%b count=%0d expected 1 1 0", empty, s_ready, count);
    end
  endtask

  task automatic test_single_word;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 32'hA5A5_0001; m_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({ram_wena, ram_addra, ram_dina, s_ready, m_valid} !== {4'hF, 8'h00, 32'hA5A5_0001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_push: wena=%h addra=%h dina=%h s_ready=%b m_valid=%b expected f 00 a5a50001 1 0",
               ram_wena, ram_addra, ram_dina, s_ready, m_valid);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = '0;
    @(negedge clk);
    n_chk++;
    if ({ram_renb, ram_addrb, count, m_valid, ram_wena} !== {1'b1, 8'h00, 9'd1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL single_n1: renb=%b addrb=%h count=%0d m_valid=%b wena=%h expected 1 00 1 0 0",
               ram_renb, ram_addrb, count, m_valid, ram_wena);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({ram_dvalb, m_valid, ram_renb} !== 3'b100) begin
      n_fail++;
      $display("FAIL single_n2: dvalb=%b m_valid=%b renb=%b expected 1 0 0", ram_dvalb, m_valid, ram_renb);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({m_valid, m_data, count} !== {1'b1, 32'hA5A5_0001, 9'd1}) begin
      n_fail++;
      $display("FAIL single_n3: m_valid=%b m_data=%h count=%0d expected 1 a5a50001 1", m_valid, m_data, count);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({m_valid, count, empty} !== {1'b0, 9'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_n4: m_valid=%b count=%0d empty=%b expected 0 0 1", m_valid, count, empty);
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  // wr_ptr starts at 1 here (one earlier push), so 256 pushes wrap it back to 1.
  task automatic test_fill;
    int not_ready;
    not_ready = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1; s_data = DW'(i);
      @(negedge clk);
      if (!s_ready) not_ready++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (not_ready != 0) begin
      n_fail++;
      $display("FAIL fill_ready: s_ready low on %0d of 256 pushes, expected 0", not_ready);
    end
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++;
    if ({full, s_ready, count, ram_wena, ram_addra} !== {1'b1, 1'b0, 9'd256, 4'h0, 8'h01}) begin
      n_fail++;
      $display("FAIL fill_full: full=%b s_ready=%b count=%0d wena=%h addra=%h expected 1 0 256 0 01",
               full, s_ready, count, ram_wena, ram_addra);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({count, m_valid, m_data} !== {9'd256, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL fill_refused: count=%0d m_valid=%b m_data=%h expected 256 1 0", count, m_valid, m_data);
    end
  endtask

  task automatic test_full_push_pop;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 32'h0000_1234; m_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({m_valid, m_data, s_ready, ram_wena} !== {1'b1, 32'd0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL full_pushpop: m_valid=%b m_data=%h s_ready=%b wena=%h expected 1 0 0 0",
               m_valid, m_data, s_ready, ram_wena);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({count, full, s_ready, m_data} !== {9'd255, 1'b0, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL full_after: count=%0d full=%b s_ready=%b m_data=%h expected 255 0 1 1",
               count, full, s_ready, m_data);
    end
  endtask

  task automatic test_drain;
    int exp_v;
    int cyc;
    int bad;
    exp_v = 1; cyc = 0; bad = 0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    while (exp_v < 256 && cyc < 2000) begin
      @(negedge clk);
      if (m_valid) begin
        n_chk++;
        if (m_data !== DW'(exp_v)) begin
          n_fail++;
          $display("FAIL drain_data: got %h expected %h", m_data, DW'(exp_v));
        end
        exp_v++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    n_chk++;
    if (exp_v != 256) begin
      n_fail++;
      $display("FAIL drain_timeout: drained up to %0d expected 256", exp_v);
    end
    @(negedge clk);
    n_chk++;
    if ({empty, count, m_valid, ram_addrb} !== {1'b1, 9'd0, 1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL drain_end: empty=%b count=%0d m_valid=%b addrb=%h expected 1 0 0 01",
               empty, count, m_valid, ram_addrb);
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    logic [AW-1:0] prev_wr;
    int accepted, cyc, wraps, ob_occ;
    accepted = 0; cyc = 0; wraps = 0; ob_occ = 0; prev_wr = 8'h00;
    while ((accepted < 10000 || q.size() != 0) && cyc < 60000) begin
      @(posedge clk); #1;
      s_valid = (accepted < 10000) && ($urandom_range(0, 9) < 7);
      s_data  = $urandom;
      if (accepted >= 10000)         m_ready = 1'b1;
      else if (((cyc / 1500) % 2) == 0) m_ready = ($urandom_range(0, 9) < 8);
      else                            m_ready = ($urandom_range(0, 9) < 2);
      @(negedge clk);
      n_chk++;
      if (int'(count) != q.size()) begin
        n_fail++;
        $display("FAIL rand_count: got %0d expected %0d", count, q.size());
      end
      n_chk++;
      if (m_valid !== (ob_occ != 0)) begin
        n_fail++;
        $display("FAIL rand_m_valid: got %b expected %b", m_valid, (ob_occ != 0));
      end
      if (m_valid && m_ready) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 'x;
        n_chk++;
        if (m_data !== exp_d) begin
          n_fail++;
          $display("FAIL rand_data: got %h expected %h", m_data, exp_d);
        end
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        accepted++;
        if (prev_wr == 8'hFF && ram_addra == 8'h00) wraps++;
        prev_wr = ram_addra;
      end
      ob_occ = ob_occ + (ram_dvalb ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (ob_occ > 2) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_ob_occ: output buffer holds %0d expected at most 2", ob_occ);
      end
      cyc++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (accepted != 10000 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_complete: accepted=%0d left=%0d expected 10000 0", accepted, q.size());
    end
    n_chk++;
    if (wraps != 39) begin
      n_fail++;
      $display("FAIL rand_wrap: got %0d FF->00 wraps expected 39", wraps);
    end
    n_chk++;
    if ({empty, count, lat_err} !== {1'b1, 9'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rand_end: empty=%b count=%0d lat_err=%b expected 1 0 0", empty, count, lat_err);
    end
  endtask

  task automatic test_reset_mid_traffic;
    logic [RV_W-1:0] obs;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 32'hC0DE_0000 + DW'(i);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (count !== 9'd5) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d expected 5", count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    obs = {s_ready, m_valid, m_data, ram_addra, ram_wena, ram_dina, ram_addrb, ram_renb, count, full, empty, lat_err};
    n_chk++;
    if (obs !== RST_VEC) begin
      n_fail++;
      $display("FAIL midrst_values: got %h expected %h", obs, RST_VEC);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    force_dval = 1'b1;  // stale read return in the first cycle after release must be ignored
    @(negedge clk);
    n_chk++;
    if ({empty, s_ready, m_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL midrst_release: empty=%b s_ready=%b m_valid=%b expected 1 1 0", empty, s_ready, m_valid);
    end
    @(posedge clk); #1;
    force_dval = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({m_valid, count, lat_err} !== {1'b0, 9'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_stale: m_valid=%b count=%0d lat_err=%b expected 0 0 0", m_valid, count, lat_err);
    end
  endtask

  task automatic test_latchk;
    logic exp_err;
`ifdef SDPRAM_FIFO_LATCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(posedge clk); #1;
    force_dval = 1'b1;
    @(negedge clk);
    n_chk++;
    if (lat_err !== 1'b0) begin
      n_fail++;
      $display("FAIL latchk_pre: lat_err=%b expected 0", lat_err);
    end
    @(posedge clk); #1;
    force_dval = 1'b0;
    @(negedge clk);
    n_chk++;
    if (lat_err !== exp_err) begin
      n_fail++;
      $display("FAIL latchk_set: lat_err=%b expected %b", lat_err, exp_err);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (lat_err !== exp_err) begin
      n_fail++;
      $display("FAIL latchk_hold: lat_err=%b expected %b", lat_err, exp_err);
    end
    rst = 1'b0;
    #2;
    n_chk++;
    if ({lat_err, m_valid, count} !== {1'b0, 1'b0, 9'd0}) begin
      n_fail++;
      $display("FAIL latchk_reset: lat_err=%b m_valid=%b count=%0d expected 0 0 0", lat_err, m_valid, count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; force_dval = 1'b0;
    test_reset;
    test_single_word;
    test_fill;
    test_full_push_pop;
    test_drain;
    test_random;
    test_reset_mid_traffic;
    test_latchk;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdpram_fifo_ctrl.md
# sdpram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of `simple_dual_port_ram` and drives both of its ports. It turns a valid/ready push stream into port-A writes and turns port-B reads back into a valid/ready pop stream. A 2-entry output buffer absorbs the RAM's one-cycle read latency so that `m_valid`/`m_data` are registered and backpressure-safe.

## Interface
- `DATA_WIDTH`, 32: word width; must match the RAM.
- `ADDR_WIDTH`, 8: RAM address width. `MEM_DEPTH = 2**ADDR_WIDTH`.
- `STRB_WIDTH`, `DATA_WIDTH/8`: byte-strobe width of RAM port A.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `s_valid` in 1: push request.
- `s_data` in DATA_WIDTH: push word.
- `s_ready` out 1: push accepted when `s_valid && s_ready`.
- `m_valid` out 1: pop word available.
- `m_data` out DATA_WIDTH: pop word.
- `m_ready` in 1: pop taken when `m_valid && m_ready`.
- `ram_addra` out ADDR_WIDTH: write address (`wr_ptr`).
- `ram_wena` out STRB_WIDTH: all ones on a write cycle, otherwise 0.
- `ram_dina` out DATA_WIDTH: write data.
- `ram_addrb` out ADDR_WIDTH: read address (`rd_ptr`).
- `ram_renb` out 1: read issue.
- `ram_doutb` in DATA_WIDTH: read data.
- `ram_dvalb` in 1: read data valid, one cycle after `ram_renb`.
- `count` out ADDR_WIDTH+1: total words held (RAM + in flight + output buffer).
- `full` out 1: `count == MEM_DEPTH`.
- `empty` out 1: `count == 0`.
- `lat_err` out 1: sticky latency error (see Configuration).

## Operation
- **Push.** `s_ready = !full`, decoded from the registered `count`. An accepted push drives `ram_wena` to all ones, `ram_addra = wr_ptr`, and `ram_dina = s_data` combinationally in the same cycle. `wr_ptr` increments at the edge and wraps from `MEM_DEPTH-1` to 0 by natural overflow.
- **Read issue.** `ram_cnt` counts words written but not yet read. `ram_renb` asserts when both hold:
  - `ram_cnt > 0`;
  - `ob_cnt + inflight - pop_now < 2`, where `ob_cnt` is output-buffer occupancy (0..2), `inflight` is 1 if `ram_renb` was high last cycle, and `pop_now` is `m_valid && m_ready`.
- **Read update.** When `ram_renb` is high, `ram_addrb = rd_ptr`, and `rd_ptr` increments with wrap at the edge. `ram_addrb` otherwise holds `rd_ptr`.
- **Capture.** `ram_doutb` is written into the output buffer when `ram_dvalb` is high. The output buffer is a 2-entry FIFO whose head drives `m_data`; `m_valid = (ob_cnt != 0)`.
- **Count.** `count` increments on push, decrements on pop, and is unchanged when both occur.
- **Simultaneous push and pop when full.** The pop is taken, the push is refused (`s_ready` is 0), and `full` deasserts next cycle. There is no same-cycle pass-through of freed space.
- **Push into an empty FIFO.** There is no write-to-read bypass. Since `ram_cnt == 0`, no read issues that cycle.
- **Address hazard.** A same-address read and write cannot occur: `ram_cnt > 0` and `count <= MEM_DEPTH` together imply `rd_ptr != wr_ptr` whenever a write is accepted.
- **Reset.** Asserting `rst` at any time clears the pointers, `ram_cnt`, the output buffer, `count`, and `lat_err`. Any RAM read in flight at reset is discarded: `ram_dvalb` is ignored for the first cycle after release.

## Timing
- **Reset values:** `s_ready=1`, `m_valid=0`, `m_data=0`, `ram_addra=0`, `ram_wena=0`, `ram_dina=0`, `ram_addrb=0`, `ram_renb=0`, `count=0`, `full=0`, `empty=1`, `lat_err=0`.
- **Push-to-pop latency into an empty FIFO:**
  - push accepted in cycle N;
  - `ram_renb` in N+1;
  - `ram_dvalb` in N+2;
  - `m_valid` high in N+3.
- **Throughput.** Sustained throughput is one push and one pop per cycle with `m_ready` held high.
- **Backpressure.** With `m_ready` low, at most 2 words are buffered beyond the RAM, and no read is issued that would overflow the output buffer.
- **Combinational paths.** Only from `s_valid`/`s_data` to the `ram_*` port-A outputs, and from `m_ready` to `ram_renb`. All other outputs are registered.

## Configuration
- **`SDPRAM_FIFO_LATCHK_EN` defined:** `lat_err` sets and stays set until reset when either:
  - `ram_dvalb` is high and `ram_renb` was low in the previous cycle; or
  - `ram_renb` was high and `ram_dvalb` is low in the current cycle.

  The cycle after reset release is exempt.
- **Not defined:** `lat_err` is tied to 0 and no checker logic is built.

## Test plan
- **Reset mid-traffic.** Assert `rst` low during streaming with `count=5`. Required: all outputs return to the reset values listed above; after release `empty=1`, `s_ready=1`.
- **Single word.** Push `32'hA5A5_0001` into an empty FIFO with `m_ready=1`. Required: `m_valid` goes high exactly 3 cycles later with `m_data=32'hA5A5_0001`; `count` goes 1 then 0.
- **Fill and drain.** Push 256 words (0..255) with `m_ready=0`. Required: `full=1` and `s_ready=0` after the 256th push with `count=256`; a 257th `s_valid` is refused. Then drain and check the data comes out 0..255 in order.
- **Full with simultaneous push and pop.** While full, assert `s_valid` and `m_ready` together for one cycle. Required: one pop, no push, `count=255` next cycle.
- **Wrap and backpressure.** Stream 10000 `$random` words with random `s_valid`/`m_ready`, compared against a scoreboard queue. Required: order preserved, no loss, pointers wrap from 0xFF to 0x00, `ob_cnt` never exceeds 2.
- **Latency checker** (with `SDPRAM_FIFO_LATCHK_EN`). Force a spurious `ram_dvalb=1` with no preceding `ram_renb`. Required: `lat_err=1` the next cycle, held until reset.
